fifo_uart_tx: RTL and testbench

- Downstream drain stage for the single-clock 8-bit FIFO.
- Pops one byte at a time through the FIFO's read port and serialises it onto an asynchronous serial line:
  - 1 start bit, 8 data bits LSB-first, optional even parity, 1 or 2 stop bits.
- Keeps draining while the FIFO is non-empty and the block is enabled.
- Reports busy status, a per-frame done pulse and a running frame count.

---
 rtl/fifo_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drain stage for a single-clock 8-bit FIFO. Pops one byte at a time and
//   serialises it as an asynchronous frame: start bit, 8 data bits LSB first,
//   optional even parity, 1 or 2 stop bits. Keeps draining while enabled and
//   the FIFO is non-empty.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (2..65535)
//   PARITY_EN    : 1 inserts an even-parity bit after data bit 7
//   STOP_BITS    : number of stop bits (1 or 2)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset (deassert synchronously)
//   en         in   permission to start new frames, sampled in IDLE only
//   fifo_empty in   FIFO empty flag
//   fifo_data  in   FIFO registered read data (valid cycle after the pop)
//   fifo_rd_en out  one-cycle pop request
//   tx         out  registered serial line, idle high
//   busy       out  high from the pop cycle through the last stop-bit cycle
//   tx_done    out  one-cycle pulse in the first IDLE cycle after a frame
//   frame_cnt  out  frames completed since reset, wraps at 16 bits
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] frame_cnt
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] baud_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shreg_reg;
  logic          parity_reg;
  logic          tx_reg;
  logic          tx_done_reg;
  logic [15:0]   frame_cnt_reg;

  logic baud_end;
  logic pop;
  logic stop_end;

  assign baud_end = (baud_reg == CW'(CLKS_PER_BIT - 1));
  // Last cycle of the final stop bit; bit_idx counts stop bits in STOP.
  assign stop_end = (state_reg == S_STOP) && baud_end &&
                    (bit_idx_reg == 3'(STOP_BITS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (pop) state_next = S_FETCH;
      S_FETCH:  state_next = S_START;
      S_START:  if (baud_end) state_next = S_DATA;
      S_DATA: begin
        if (baud_end && (bit_idx_reg == 3'd7)) begin
          state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (baud_end) state_next = S_STOP;
      S_STOP:   if (stop_end) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output logic. The pop is also gated by rst_n so no request escapes
  // while reset is held.
  always_comb begin
    pop        = (state_reg == S_IDLE) && en && !fifo_empty && rst_n;
    fifo_rd_en = pop;
    busy       = (state_reg != S_IDLE) || pop;
  end

  // Datapath: baud counter, bit index, shift register and line register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_reg      <= '0;
      bit_idx_reg   <= '0;
      shreg_reg     <= '0;
      parity_reg    <= 1'b0;
      tx_reg        <= 1'b1;
      tx_done_reg   <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      tx_done_reg <= stop_end;
      if (stop_end) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end

      if ((state_reg == S_IDLE) || (state_reg == S_FETCH) || baud_end) begin
        baud_reg <= '0;
      end else begin
        baud_reg <= baud_reg + CW'(1);
      end

      case (state_reg)
        S_IDLE: begin
          tx_reg <= 1'b1;
        end
        S_FETCH: begin
          shreg_reg   <= fifo_data;
          parity_reg  <= ^fifo_data;
          bit_idx_reg <= '0;
          tx_reg      <= 1'b0;
        end
        S_START: begin
          if (baud_end) tx_reg <= shreg_reg[0];
        end
        S_DATA: begin
          if (baud_end) begin
            shreg_reg   <= {1'b0, shreg_reg[7:1]};
            // 3-bit index wraps 7 -> 0, ready to count stop bits.
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
              tx_reg <= (PARITY_EN != 0) ? parity_reg : 1'b1;
            end else begin
              // shreg_reg[1] becomes bit 0 after this shift.
              tx_reg <= shreg_reg[1];
            end
          end
        end
        S_PARITY: begin
          if (baud_end) tx_reg <= 1'b1;
        end
        S_STOP: begin
          if (baud_end) bit_idx_reg <= bit_idx_reg + 3'd1;
        end
        default: begin
          tx_reg <= 1'b1;
        end
      endcase
    end
  end

  assign tx        = tx_reg;
  assign tx_done   = tx_done_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx. Two instances at CLKS_PER_BIT=4:
//   u_a : no parity, 1 stop bit
//   u_p : even parity, 2 stop bits
// Each has its own small FIFO model with registered read data.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A (defaults) ----------------
  logic        rst_n_a, en_a, empty_a, rd_en_a, tx_a, busy_a, done_a;
  logic [7:0]  data_a = 8'h00;
  logic [15:0] cnt_a;
  logic [7:0]  mem_a [0:15];
  int          wr_a = 0, rd_a = 0, pops_a = 0, dbl_a = 0;
  logic        prev_rd_a = 1'b0;

  assign empty_a = (rd_a == wr_a);

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n_a), .en(en_a), .fifo_empty(empty_a),
    .fifo_data(data_a), .fifo_rd_en(rd_en_a), .tx(tx_a), .busy(busy_a),
    .tx_done(done_a), .frame_cnt(cnt_a)
  );

  always @(posedge clk) begin
    prev_rd_a <= rd_en_a;
    if (rd_en_a && prev_rd_a) dbl_a <= dbl_a + 1;
    if (rd_en_a && (rd_a != wr_a)) begin
      data_a <= mem_a[rd_a % 16];
      rd_a   <= rd_a + 1;
      pops_a <= pops_a + 1;
    end
  end

  // ---------------- instance P (parity, 2 stop bits) ----------------
  logic        rst_n_p, en_p, empty_p, rd_en_p, tx_p, busy_p, done_p;
  logic [7:0]  data_p = 8'h00;
  logic [15:0] cnt_p;
  logic [7:0]  mem_p [0:15];
  int          wr_p = 0, rd_p = 0, pops_p = 0, dbl_p = 0;
  logic        prev_rd_p = 1'b0;

  assign empty_p = (rd_p == wr_p);

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) u_p (
    .clk(clk), .rst_n(rst_n_p), .en(en_p), .fifo_empty(empty_p),
    .fifo_data(data_p), .fifo_rd_en(rd_en_p), .tx(tx_p), .busy(busy_p),
    .tx_done(done_p), .frame_cnt(cnt_p)
  );

  always @(posedge clk) begin
    prev_rd_p <= rd_en_p;
    if (rd_en_p && prev_rd_p) dbl_p <= dbl_p + 1;
    if (rd_en_p && (rd_p != wr_p)) begin
      data_p <= mem_p[rd_p % 16];
      rd_p   <= rd_p + 1;
      pops_p <= pops_p + 1;
    end
  end

  // ---------------- instance select for the frame checker ----------------
  int          sel = 0;
  logic        cur_tx, cur_busy, cur_done;
  logic [15:0] cur_cnt;
  assign cur_tx   = (sel == 1) ? tx_p   : tx_a;
  assign cur_busy = (sel == 1) ? busy_p : busy_a;
  assign cur_done = (sel == 1) ? done_p : done_a;
  assign cur_cnt  = (sel == 1) ? cnt_p  : cnt_a;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, got);
    end
  endtask

  task automatic push_a(input logic [7:0] b);
    mem_a[wr_a % 16] = b;
    wr_a = wr_a + 1;
  endtask

  task automatic push_p(input logic [7:0] b);
    mem_p[wr_p % 16] = b;
    wr_p = wr_p + 1;
  endtask

  // Waits for the start bit, then checks every line cycle of the frame
  // against bits[] (bit b held for CPB cycles, busy high throughout), then
  // the tx_done pulse and frame count in the following cycle.
  // gap returns the number of high line cycles seen before the start bit.
  task automatic run_frame(input int s, input logic [7:0] data, input logic [11:0] bits,
                           input int nbits, input logic [15:0] exp_cnt, output int gap);
    bit found;
    bit ok;
    int bad_c;
    sel   = s;
    gap   = 0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cur_tx == 1'b0) begin
        found = 1;
        break;
      end
      gap++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL start_timeout dut%0d byte %02h: got no start bit expected one within 200 cycles", s, data);
      return;
    end
    for (int b = 0; b < nbits; b++) begin
      ok    = 1;
      bad_c = 0;
      for (int c = 0; c < CPB; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (cur_tx !== bits[b] || cur_busy !== 1'b1 || cur_done !== 1'b0) begin
          ok    = 0;
          bad_c = c;
        end
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL line_bit dut%0d byte %02h bit %0d cycle %0d: got tx=%b busy=%b done=%b expected tx=%b busy=1 done=0",
                 s, data, b, bad_c, cur_tx, cur_busy, cur_done, bits[b]);
      end
    end
    @(negedge clk);
    chk($sformatf("tx_done dut%0d byte %02h", s, data), {31'd0, cur_done}, 32'd1);
    chk($sformatf("frame_cnt dut%0d byte %02h", s, data), {16'd0, cur_cnt}, {16'd0, exp_cnt});
  endtask

  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic [11:0] bits;   // line bits in send order, bit 0 = start bit
    int          nbits;
    logic [15:0] cnt;    // frame_cnt expected after this frame
    int          gap;    // high cycles between previous stop and start, -1 = unchecked
  } vec_t;

  vec_t vecs [0:3];

  task automatic run_vec(input int lo, input int hi);
    int g;
    for (int i = lo; i < hi; i++) begin
      run_frame(vecs[i].sel, vecs[i].data, vecs[i].bits, vecs[i].nbits, vecs[i].cnt, g);
      // run_frame returned in the tx_done (IDLE) cycle, so add it back.
      if (vecs[i].gap >= 0)
        chk($sformatf("gap dut%0d byte %02h", vecs[i].sel, vecs[i].data), g + 1, vecs[i].gap);
    end
  endtask

  int  g0;
  int  found_start;

  initial begin
    // Hand-computed frames: {stop(s), [parity], data[7:0], start}
    vecs[0] = '{0, 8'h22, {2'b00, 1'b1, 8'h22, 1'b0}, 10, 16'd3, -1};
    vecs[1] = '{0, 8'h33, {2'b00, 1'b1, 8'h33, 1'b0}, 10, 16'd4, 2};
    // 0xA5 has four ones -> parity 0; 0x07 has three ones -> parity 1
    vecs[2] = '{1, 8'hA5, {1'b1, 1'b1, 1'b0, 8'hA5, 1'b0}, 12, 16'd1, -1};
    vecs[3] = '{1, 8'h07, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 12, 16'd2, 2};

    rst_n_a = 1'b0; rst_n_p = 1'b0;
    en_a    = 1'b1; en_p    = 1'b0;
    push_a(8'hA5);
    push_p(8'hA5);
    push_p(8'h07);

    // Reset held with data waiting and en high: nothing may move.
    repeat (3) @(negedge clk);
    chk("reset tx", {31'd0, tx_a}, 32'd1);
    chk("reset busy", {31'd0, busy_a}, 32'd0);
    chk("reset rd_en", {31'd0, rd_en_a}, 32'd0);
    chk("reset frame_cnt", {16'd0, cnt_a}, 32'd0);
    chk("reset tx_done", {31'd0, done_a}, 32'd0);
    rst_n_a = 1'b1; rst_n_p = 1'b1;

    // Single byte 0xA5
    run_frame(0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 16'd1, g0);
    chk("single pops", pops_a, 1);

    // Enabled with an empty FIFO: no pop, idle
    repeat (20) @(negedge clk);
    chk("empty pops", pops_a, 1);
    chk("empty busy", {31'd0, busy_a}, 32'd0);

    // Three bytes queued, en dropped during frame 1 data bits
    en_a = 1'b0;
    push_a(8'h11); push_a(8'h22); push_a(8'h33);
    @(negedge clk);
    en_a = 1'b1;
    fork
      run_frame(0, 8'h11, {2'b00, 1'b1, 8'h11, 1'b0}, 10, 16'd2, g0);
      begin
        repeat (12) @(negedge clk);
        en_a = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    chk("en gated pops", pops_a, 2);
    chk("en gated tx", {31'd0, tx_a}, 32'd1);
    en_a = 1'b1;
    run_vec(0, 2);
    chk("en resumed pops", pops_a, 4);

    // Reset during data bit 3 of 0xF0 (bit 3 = 0, so the line is low)
    push_a(8'hF0);
    found_start = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_a == 1'b0) begin
        found_start = 1;
        break;
      end
    end
    chk("midreset start seen", found_start, 1);
    repeat (CPB + 3 * CPB + 1) @(negedge clk);
    chk("midreset line low in bit3", {31'd0, tx_a}, 32'd0);
    rst_n_a = 1'b0;
    #1;
    chk("midreset tx", {31'd0, tx_a}, 32'd1);
    chk("midreset frame_cnt", {16'd0, cnt_a}, 32'd0);
    chk("midreset busy", {31'd0, busy_a}, 32'd0);
    push_a(8'h3C);
    @(negedge clk);
    chk("midreset rd_en held", {31'd0, rd_en_a}, 32'd0);
    rst_n_a = 1'b1;
    run_frame(0, 8'h3C, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 16'd1, g0);

    // Counter wrap: preload 65535 completed frames, send one more
    @(negedge clk);
    force u_a.frame_cnt_reg = 16'hFFFF;
    @(negedge clk);
    release u_a.frame_cnt_reg;
    @(negedge clk);
    chk("preload frame_cnt", {16'd0, cnt_a}, 32'h0000FFFF);
    push_a(8'h81);
    run_frame(0, 8'h81, {2'b00, 1'b1, 8'h81, 1'b0}, 10, 16'h0000, g0);

    // Parity + 2 stop bits, back to back
    en_p = 1'b1;
    run_vec(2, 4);
    chk("parity pops", pops_p, 2);

    repeat (5) @(negedge clk);
    chk("no double pop a", dbl_a, 0);
    chk("no double pop p", dbl_p, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
